// File: rtl/alu_op_pkg.sv
// Shared encodings and the RV32I-to-ALU decode function for alu_op_decoder.
package alu_op_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SR  = 4'b0110;
  localparam logic [3:0] OP_SL  = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BNE = 4'b1010;
  localparam logic [3:0] OP_BLT = 4'b1011;
  localparam logic [3:0] OP_BGE = 4'b1100;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b10
  } buf_state_e;

  typedef struct packed {
    logic [3:0] op;
    logic       src;
    logic       branch;
    logic       illegal;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

  localparam dec_t DEC_ILLEGAL = '{op: OP_ADD, src: 1'b0, branch: 1'b0, illegal: 1'b1};

  function automatic dec_t alu_decode(input logic [6:0] opcode,
                                      input logic [2:0] funct3,
                                      input logic [6:0] funct7);
    dec_t d;
    d = DEC_ILLEGAL;
    case (opcode)
      OPC_R, OPC_I: begin
        d.illegal = 1'b0;
        case (funct3)
          3'b000:  d.op = ((opcode == OPC_R) && funct7[5]) ? OP_SUB : OP_ADD;
          3'b001:  d.op = OP_SL;
          3'b100:  d.op = OP_XOR;
          3'b110:  d.op = OP_OR;
          3'b111:  d.op = OP_AND;
          // funct7[5] set selects SRA, which decodes as illegal
          3'b101:  begin
            if (funct7[5]) begin
              d.illegal = 1'b1;
            end else begin
              d.op = OP_SR;
            end
          end
          default: d.illegal = 1'b1;
        endcase
        d.src = (opcode == OPC_I) && !d.illegal;
      end
      OPC_LUI: d = '{op: OP_LUI, src: 1'b1, branch: 1'b0, illegal: 1'b0};
      OPC_LOAD, OPC_STORE, OPC_JALR, OPC_JAL:
        d = '{op: OP_ADD, src: 1'b1, branch: 1'b0, illegal: 1'b0};
      OPC_BRANCH: begin
        case (funct3)
          3'b000:  d = '{op: OP_BEQ, src: 1'b0, branch: 1'b1, illegal: 1'b0};
          3'b001:  d = '{op: OP_BNE, src: 1'b0, branch: 1'b1, illegal: 1'b0};
          3'b100:  d = '{op: OP_BLT, src: 1'b0, branch: 1'b1, illegal: 1'b0};
          3'b101:  d = '{op: OP_BGE, src: 1'b0, branch: 1'b1, illegal: 1'b0};
          default: d = DEC_ILLEGAL;
        endcase
      end
      default: d = DEC_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_op_skid.sv
// Generic valid/ready payload buffer: output register plus optional skid
// register (ALU_OP_DEC_SKID_EN); without it, a single pass-through stage.
module alu_op_skid
  import alu_op_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

`ifdef ALU_OP_DEC_SKID_EN
  buf_state_e   state_q;
  logic [W-1:0] out_q;
  logic [W-1:0] skid_q;
  logic         ready_q;
  logic         accept_s;
  logic         drain_s;

  assign accept_s = in_valid_i && ready_q;
  assign drain_s  = (state_q != BUF_EMPTY) && out_ready_i;

  // Occupancy FSM; ready is registered and low only while both entries hold data
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BUF_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (accept_s) begin
            out_q   <= in_data_i;
            state_q <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept_s && drain_s) begin
            out_q <= in_data_i;
          end else if (accept_s) begin
            skid_q  <= in_data_i;
            state_q <= BUF_FULL;
            ready_q <= 1'b0;
          end else if (drain_s) begin
            state_q <= BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (drain_s) begin
            out_q   <= skid_q;
            state_q <= BUF_ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= BUF_EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = (state_q != BUF_EMPTY);
  assign out_data_o  = out_q;
`else
  logic         valid_q;
  logic [W-1:0] out_q;
  logic         accept_s;

  assign in_ready_o = out_ready_i || !valid_q;
  assign accept_s   = in_valid_i && in_ready_o;

  // Single output stage: load on accept, empty on drain without refill
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (accept_s) begin
      valid_q <= 1'b1;
      out_q   <= in_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = out_q;
`endif

endmodule

// File: rtl/alu_op_decoder.sv
// Registered RV32I ALU-operation decode stage with valid/ready on both sides.
// Define ALU_OP_DEC_SKID_EN to add the skid entry and a registered instr_ready_o.
module alu_op_decoder
  import alu_op_pkg::*;
#(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [6:0]           opcode_i,
  input  logic [2:0]           funct3_i,
  input  logic [6:0]           funct7_i,
  output logic                 op_valid_o,
  input  logic                 op_ready_i,
  output logic [3:0]           ALU_Operation_o,
  output logic                 ALU_Src_o,
  output logic                 Branch_o,
  output logic                 Illegal_o,
  output logic [ILL_CNT_W-1:0] illegal_count_o
);

  dec_t                 dec_s;
  dec_t                 out_s;
  logic [ILL_CNT_W-1:0] ill_cnt_q;
  logic [ILL_CNT_W-1:0] ill_cnt_d;

  assign dec_s = alu_decode(opcode_i, funct3_i, funct7_i);

  alu_op_skid #(.W(DEC_W)) u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (instr_valid_i),
    .in_ready_o  (instr_ready_o),
    .in_data_i   (dec_s),
    .out_valid_o (op_valid_o),
    .out_ready_i (op_ready_i),
    .out_data_o  (out_s)
  );

  // Saturating count of accepted illegal words
  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (instr_valid_i && instr_ready_o && dec_s.illegal && (ill_cnt_q != '1)) begin
      ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
    end else begin
      ill_cnt_d = ill_cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      ill_cnt_q <= '0;
    end else begin
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign ALU_Operation_o = out_s.op;
  assign ALU_Src_o       = out_s.src;
  assign Branch_o        = out_s.branch;
  assign Illegal_o       = out_s.illegal;
  assign illegal_count_o = ill_cnt_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Self-checking bench for alu_op_decoder: decode table, stall/reset sequences
// and randomized traffic against a queue-based reference model.
module tb_alu_op_decoder;

  logic       clk;
  logic       reset;
  logic       instr_valid_i;
  logic       instr_ready_o;
  logic [6:0] opcode_i;
  logic [2:0] funct3_i;
  logic [6:0] funct7_i;
  logic       op_valid_o;
  logic       op_ready_i;
  logic [3:0] ALU_Operation_o;
  logic       ALU_Src_o;
  logic       Branch_o;
  logic       Illegal_o;
  logic [7:0] illegal_count_o;

  alu_op_decoder dut (
    .clk             (clk),
    .reset           (reset),
    .instr_valid_i   (instr_valid_i),
    .instr_ready_o   (instr_ready_o),
    .opcode_i        (opcode_i),
    .funct3_i        (funct3_i),
    .funct7_i        (funct7_i),
    .op_valid_o      (op_valid_o),
    .op_ready_i      (op_ready_i),
    .ALU_Operation_o (ALU_Operation_o),
    .ALU_Src_o       (ALU_Src_o),
    .Branch_o        (Branch_o),
    .Illegal_o       (Illegal_o),
    .illegal_count_o (illegal_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected word packing: {op[3:0], src, branch, illegal}
  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [6:0] exp;
  } vec_t;

  localparam int NV = 30;
  localparam logic [6:0] ILL = 7'b0000001;

  vec_t       tbl [NV];
  logic [6:0] mq [$];
  int         mcount;
  int         n_vec;
  int         n_err;
  int         alu_f3 [8] = '{0, 7, -1, -1, 4, 6, 3, 2};
  int         br_f3  [8] = '{8, 10, -1, -1, 11, 12, -1, -1};
  logic [6:0] opc_pool [9] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0000011,
                               7'b0100011, 7'b1100111, 7'b1101111, 7'b1100011,
                               7'b1110011};

  function automatic logic [6:0] ref_decode(input logic [6:0] opc, input logic [2:0] f3,
                                            input logic [6:0] f7);
    int a;
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      a = alu_f3[f3];
      if (f3 == 3'd5 && f7[5]) a = -1;
      if (f3 == 3'd0 && f7[5] && opc == 7'b0110011) a = 1;
      if (a < 0) return ILL;
      return {a[3:0], opc == 7'b0010011, 1'b0, 1'b0};
    end
    if (opc == 7'b0110111) return 7'b0101100;
    if (opc == 7'b0000011 || opc == 7'b0100011 || opc == 7'b1100111 || opc == 7'b1101111)
      return 7'b0000100;
    if (opc == 7'b1100011) begin
      a = br_f3[f3];
      if (a < 0) return ILL;
      return {a[3:0], 1'b0, 1'b1, 1'b0};
    end
    return ILL;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dut_word();
    return {ALU_Operation_o, ALU_Src_o, Branch_o, Illegal_o};
  endfunction

  // One clock: drive, check against model, advance model at the edge.
  task automatic cycle(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic ordy);
    logic exp_rdy, acc, drn;
    logic [6:0] w;
    instr_valid_i = v; opcode_i = opc; funct3_i = f3; funct7_i = f7; op_ready_i = ordy;
    #1;
`ifdef ALU_OP_DEC_SKID_EN
    exp_rdy = (mq.size() < 2);
`else
    exp_rdy = (mq.size() == 0) || ordy;
`endif
    chk("instr_ready", 32'(instr_ready_o), 32'(exp_rdy));
    chk("op_valid", 32'(op_valid_o), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("payload", 32'(dut_word()), 32'(mq[0]));
    chk("illegal_count", 32'(illegal_count_o), 32'(mcount));
    acc = v && exp_rdy;
    drn = (mq.size() != 0) && ordy;
    w = ref_decode(opc, f3, f7);
    @(posedge clk);
    if (drn) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(w);
      if (w[0] && mcount < 255) mcount++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid_i = 1'b1; opcode_i = 7'b1110011; funct3_i = 3'd0; funct7_i = 7'd0;
    op_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    instr_valid_i = 1'b0;
    mq.delete();
    mcount = 0;
    #1;
    chk("rst_op_valid", 32'(op_valid_o), 32'd0);
    chk("rst_instr_ready", 32'(instr_ready_o), 32'd1);
    chk("rst_payload", 32'(dut_word()), 32'd0);
    chk("rst_illegal_count", 32'(illegal_count_o), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0; n_err = 0; mcount = 0;
    tbl[0]  = '{7'b0110011, 3'b000, 7'b0100000, 7'b0001000};
    tbl[1]  = '{7'b0110011, 3'b000, 7'b0000000, 7'b0000000};
    tbl[2]  = '{7'b0110011, 3'b111, 7'b0000000, 7'b0010000};
    tbl[3]  = '{7'b0110011, 3'b110, 7'b0000000, 7'b0011000};
    tbl[4]  = '{7'b0110011, 3'b100, 7'b0000000, 7'b0100000};
    tbl[5]  = '{7'b0110011, 3'b001, 7'b0000000, 7'b0111000};
    tbl[6]  = '{7'b0110011, 3'b101, 7'b0000000, 7'b0110000};
    tbl[7]  = '{7'b0110011, 3'b101, 7'b0100000, 7'b0000001};
    tbl[8]  = '{7'b0110011, 3'b010, 7'b0000000, 7'b0000001};
    tbl[9]  = '{7'b0010011, 3'b000, 7'b0000000, 7'b0000100};
    tbl[10] = '{7'b0110111, 3'b011, 7'b1010101, 7'b0101100};
    tbl[11] = '{7'b1100011, 3'b001, 7'b0000000, 7'b1010010};
    tbl[12] = '{7'b0010011, 3'b100, 7'b0000000, 7'b0100100};
    tbl[13] = '{7'b0010011, 3'b000, 7'b0100000, 7'b0000100};
    tbl[14] = '{7'b0010011, 3'b101, 7'b0100000, 7'b0000001};
    tbl[15] = '{7'b0010011, 3'b011, 7'b0000000, 7'b0000001};
    tbl[16] = '{7'b0010011, 3'b001, 7'b0000000, 7'b0111100};
    tbl[17] = '{7'b0010011, 3'b101, 7'b0000000, 7'b0110100};
    tbl[18] = '{7'b0010011, 3'b111, 7'b0000000, 7'b0010100};
    tbl[19] = '{7'b0000011, 3'b010, 7'b0000000, 7'b0000100};
    tbl[20] = '{7'b0100011, 3'b010, 7'b0000000, 7'b0000100};
    tbl[21] = '{7'b1100111, 3'b000, 7'b0000000, 7'b0000100};
    tbl[22] = '{7'b1101111, 3'b000, 7'b0100000, 7'b0000100};
    tbl[23] = '{7'b1100011, 3'b000, 7'b0000000, 7'b1000010};
    tbl[24] = '{7'b1100011, 3'b100, 7'b0000000, 7'b1011010};
    tbl[25] = '{7'b1100011, 3'b101, 7'b0000000, 7'b1100010};
    tbl[26] = '{7'b1100011, 3'b110, 7'b0000000, 7'b0000001};
    tbl[27] = '{7'b1110011, 3'b000, 7'b0000000, 7'b0000001};
    tbl[28] = '{7'b1100011, 3'b010, 7'b0000000, 7'b0000001};
    tbl[29] = '{7'b0010011, 3'b110, 7'b0000000, 7'b0011100};

    reset = 1'b1; instr_valid_i = 1'b0; opcode_i = 7'd0; funct3_i = 3'd0;
    funct7_i = 7'd0; op_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // decode table, back-to-back with execute always ready
    for (int i = 0; i < NV; i++) begin
      cycle(1'b1, tbl[i].opc, tbl[i].f3, tbl[i].f7, 1'b1);
      #1;
      chk($sformatf("tbl[%0d]", i), 32'(dut_word()), 32'(tbl[i].exp));
    end
    cycle(1'b0, 7'd0, 3'd0, 7'd0, 1'b1);

    // stall: first word illegal and must stay stable, ready must drop
    cycle(1'b1, 7'b1110011, 3'd0, 7'd0, 1'b0);
    cycle(1'b1, 7'b0110111, 3'd0, 7'd0, 1'b0);
    instr_valid_i = 1'b1; op_ready_i = 1'b0; #1;
    chk("stall_ready", 32'(instr_ready_o), 32'd0);
    chk("stall_valid", 32'(op_valid_o), 32'd1);
    chk("stall_hold", 32'(dut_word()), 32'(ILL));
    @(negedge clk);
    cycle(1'b1, 7'b0110011, 3'b100, 7'd0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 7'd0, 3'd0, 7'd0, 1'b1);

    // reset while the buffer is full (or holding under stall without skid)
    cycle(1'b1, 7'b1110011, 3'd0, 7'd0, 1'b0);
    cycle(1'b1, 7'b0110111, 3'd0, 7'd0, 1'b0);
    do_reset();

    // illegal counter saturation
    for (int i = 0; i < 300; i++) cycle(1'b1, 7'b1110011, 3'd0, 7'd0, 1'b1);
    #1;
    chk("ill_saturate", 32'(illegal_count_o), 32'd255);
    @(negedge clk);
    do_reset();

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [6:0] opc;
      logic [6:0] f7;
      int k;
      k = $urandom_range(0, 9);
      if (k == 9) opc = 7'($urandom);
      else opc = opc_pool[k];
      k = $urandom_range(0, 2);
      if (k == 0) f7 = 7'b0000000;
      else if (k == 1) f7 = 7'b0100000;
      else f7 = 7'($urandom);
      cycle($urandom_range(0, 3) != 0, opc, 3'($urandom), f7, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 7'd0, 3'd0, 7'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_decoder.md
# alu_op_decoder

Registered decode stage that produces the 4-bit ALU operation code and operand controls consumed by the core's ALU. It accepts RV32I instruction fields over a valid/ready handshake, decodes them into the ALU operation encoding, and presents the result over a downstream valid/ready handshake. It sits between instruction fetch/register read and the execute stage, buffering one decoded operation when execute stalls.

## Interface
Parameters:
- ILL_CNT_W, 8, width of the saturating illegal-instruction counter

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- instr_valid_i  in  1  upstream has instruction fields
- instr_ready_o  out  1  block can accept this cycle
- opcode_i  in  7  instruction [6:0]
- funct3_i  in  3  instruction [14:12]
- funct7_i  in  7  instruction [31:25]
- op_valid_o  out  1  decoded operation valid
- op_ready_i  in  1  execute stage accepts
- ALU_Operation_o  out  4  ALU operation code
- ALU_Src_o  out  1  1 = B operand is immediate
- Branch_o  out  1  conditional branch; ALU result 0 means taken
- Illegal_o  out  1  unsupported encoding; ALU_Operation_o forced to ADD
- illegal_count_o  out  ILL_CNT_W  accepted illegal instructions, saturating

## Operation
- Encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, LUI 0101, SR 0110, SL 0111, BEQ 1000, BNE 1010, BLT 1011, BGE 1100; 1001 and 1101-1111 never emitted.
- R-type 0110011, ALU_Src 0: f3 000 -> ADD (f7[5]=0) / SUB (f7[5]=1); 111 AND; 110 OR; 100 XOR; 001 SL; 101 SR with f7[5]=0; 101 with f7[5]=1 (SRA) and 010/011 -> illegal.
- I-type 0010011, ALU_Src 1: 000 ADD, 111 AND, 110 OR, 100 XOR, 001 SL, 101 SR with f7[5]=0; 101 with f7[5]=1 and 010/011 -> illegal.
- LUI 0110111 -> LUI, ALU_Src 1. Load 0000011, store 0100011, JALR 1100111, JAL 1101111 -> ADD, ALU_Src 1.
- Branch 1100011, ALU_Src 0, Branch_o 1: 000 BEQ, 001 BNE, 100 BLT, 101 BGE; 010/011/110/111 -> illegal.
- Any other opcode -> illegal. Illegal: ALU_Operation_o ADD, ALU_Src_o 0, Branch_o 0, Illegal_o 1.
- Illegal words still flow downstream; illegal_count_o increments once per accepted illegal word, holds at all-ones.

## Timing
- Accept on instr_valid_i && instr_ready_o; decoded word appears on op_valid_o the next cycle (latency 1). Throughput 1/cycle when op_ready_i held high.
- Transfer out on op_valid_o && op_ready_i. Output payload stable while op_valid_o && !op_ready_i.
- Storage: output register + one skid register. States EMPTY (no entries), ONE (output only), FULL (output + skid). EMPTY->ONE on accept; ONE->FULL on accept without drain; FULL->ONE on drain (skid moves to output); ONE->EMPTY on drain without accept; simultaneous accept+drain in ONE stays ONE.
- instr_ready_o = registered, 0 only in FULL; never asserted with no free entry.
- Reset (any cycle, including mid-stall): state EMPTY, op_valid_o 0, instr_ready_o 1 from the cycle after reset, ALU_Operation_o ADD, ALU_Src_o 0, Branch_o 0, Illegal_o 0, illegal_count_o 0. Inputs during reset ignored; buffered words discarded.

## Configuration
- ALU_OP_DEC_SKID_EN defined: skid register present, registered instr_ready_o as above.
- Undefined: output register only; instr_ready_o = op_ready_i || !op_valid_o (combinational); FULL state absent; all other behaviour identical.

## Structure
- Package alu_op_pkg: 4-bit operation localparams, opcode localparams, decode function returning {op, src, branch, illegal}.
- Sub-module alu_op_skid: generic payload skid buffer, width parameter, honours ALU_OP_DEC_SKID_EN.

## Test plan
- Reset then R-type f3 000 f7 0100000 with op_ready_i 1 -> next cycle op_valid_o 1, ALU_Operation_o 0001, ALU_Src_o 0.
- Back-to-back stream ADDI, LUI, BNE, XOR, op_ready_i 1 -> ops 0000/0101/1010/0100 on consecutive cycles, Branch_o 1 only for BNE.
- op_ready_i 0 for 3 cycles while sending 3 words -> instr_ready_o 0 after second accept, first word held stable; release -> words delivered in order, none lost or duplicated.
- Opcode 1110011 and branch f3 110 -> Illegal_o 1, ALU_Operation_o 0000, illegal_count_o 1 then 2; 300 illegal words -> count saturates at 255.
- Reset asserted in FULL -> next cycle op_valid_o 0, instr_ready_o 1, illegal_count_o 0.
- Build without ALU_OP_DEC_SKID_EN, op_ready_i 0 -> instr_ready_o drops same cycle op_valid_o is 1; single word held.
